// File: rtl/sal_cmd_arbiter_pkg.sv
// sal_cmd_pkg: DRAM command encoding and tFAW slot count shared across the channel
package sal_cmd_pkg;
  typedef enum logic [2:0] {
    CMD_NOP = 3'd0,
    CMD_ACT = 3'd1,
    CMD_RD  = 3'd2,
    CMD_WR  = 3'd3,
    CMD_PRE = 3'd4,
    CMD_REF = 3'd5
  } cmd_t;
  localparam int NUM_FAW_SLOTS = 4;
endpackage

// File: rtl/sal_cmd_arbiter_if.sv
// sal_cmd_arbiter_if: per-bank request lanes, grant vector and registered command bus
interface sal_cmd_arbiter_if #(
  parameter int NUM_BANKS  = 4,
  parameter int BA_WIDTH   = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4
);
  import sal_cmd_pkg::*;
  logic [NUM_BANKS-1:0]            req_valid_i;
  logic [NUM_BANKS*3-1:0]          req_cmd_i;
  logic [NUM_BANKS*ADDR_WIDTH-1:0] req_addr_i;
  logic [NUM_BANKS*ID_WIDTH-1:0]   req_id_i;
  logic [NUM_BANKS-1:0]            gnt_o;
  logic                            cmd_valid_o;
  cmd_t                            cmd_o;
  logic [BA_WIDTH-1:0]             cmd_ba_o;
  logic [ADDR_WIDTH-1:0]           cmd_addr_o;
  logic [ID_WIDTH-1:0]             cmd_id_o;
  modport master (
    output req_valid_i, req_cmd_i, req_addr_i, req_id_i,
    input  gnt_o, cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o, cmd_id_o
  );
  modport slave (
    input  req_valid_i, req_cmd_i, req_addr_i, req_id_i,
    output gnt_o, cmd_valid_o, cmd_o, cmd_ba_o, cmd_addr_o, cmd_id_o
  );
endinterface

// File: rtl/sal_cmd_arbiter_rr_pick.sv
// sal_rr_pick: picks the first eligible requester searching upward (mod N) from ptr
module sal_rr_pick #(
  parameter int N = 4,
  localparam int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [PW-1:0] idx,
  output logic          any
);
  always_comb begin
    idx = ptr;
    any = 1'b0;
    for (int i = N - 1; i >= 0; i--)
      if (elig[ptr + PW'(i)]) begin
        idx = ptr + PW'(i);
        any = 1'b1;
      end
    pick = any ? N'(1) << idx : '0;
  end
endmodule

// File: rtl/sal_cmd_arbiter.sv
// sal_cmd_arbiter: one command per cycle onto the DRAM bus, column over row, round-robin per class, tFAW-limited ACTs
module sal_cmd_arbiter
  import sal_cmd_pkg::*;
#(
  parameter int NUM_BANKS  = 4,
  parameter int BA_WIDTH   = 2,
  parameter int ADDR_WIDTH = 16,
  parameter int ID_WIDTH   = 4,
  parameter int FAW_WIDTH  = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FAW_WIDTH-1:0] t_faw_m1_i,
  sal_cmd_arbiter_if.slave     bus
);
  localparam int SW = $clog2(NUM_FAW_SLOTS);
  logic [NUM_BANKS-1:0]  act_req, col_elig, row_elig, col_pick, row_pick;
  logic [BA_WIDTH-1:0]   col_idx, row_idx, sel;
  logic [BA_WIDTH-1:0]   col_ptr_q, col_ptr_d, row_ptr_q, row_ptr_d;
  logic                  col_any, row_any, act_gnt, faw_full;
  logic [FAW_WIDTH-1:0]  faw_cnt_q [NUM_FAW_SLOTS];
  logic [FAW_WIDTH-1:0]  faw_cnt_d [NUM_FAW_SLOTS];
  logic [NUM_FAW_SLOTS-1:0] busy;
  logic [SW-1:0]         free_idx;
  logic                  cmd_valid_q, cmd_valid_d;
  cmd_t                  cmd_q, cmd_d;
  logic [BA_WIDTH-1:0]   ba_q, ba_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ID_WIDTH-1:0]   id_q, id_d;

  always_comb begin
    for (int b = 0; b < NUM_BANKS; b++) begin
      act_req[b]  = bus.req_valid_i[b] && (bus.req_cmd_i[3*b +: 3] == CMD_ACT);
      col_elig[b] = bus.req_valid_i[b] && (bus.req_cmd_i[3*b +: 3] == CMD_RD || bus.req_cmd_i[3*b +: 3] == CMD_WR);
      row_elig[b] = (act_req[b] && !faw_full) ||
                    (bus.req_valid_i[b] && (bus.req_cmd_i[3*b +: 3] == CMD_PRE || bus.req_cmd_i[3*b +: 3] == CMD_REF));
    end
  end

  sal_rr_pick #(.N(NUM_BANKS)) u_col_pick (.elig(col_elig), .ptr(col_ptr_q), .pick(col_pick), .idx(col_idx), .any(col_any));
  sal_rr_pick #(.N(NUM_BANKS)) u_row_pick (.elig(row_elig), .ptr(row_ptr_q), .pick(row_pick), .idx(row_idx), .any(row_any));

  assign bus.gnt_o = rst ? '0 : (col_any ? col_pick : row_pick);
  assign sel       = col_any ? col_idx : row_idx;
  assign act_gnt   = !col_any && row_any && act_req[row_idx];

  // A slot is loaded on ACT and counts down; zero means free in that same cycle.
  always_comb begin
    free_idx = '0;
    for (int i = NUM_FAW_SLOTS - 1; i >= 0; i--) begin
      busy[i] = faw_cnt_q[i] != '0;
      if (!busy[i]) free_idx = SW'(i);
    end
    faw_full = &busy;
    for (int i = 0; i < NUM_FAW_SLOTS; i++)
      faw_cnt_d[i] = (act_gnt && free_idx == SW'(i)) ? t_faw_m1_i :
                     busy[i] ? faw_cnt_q[i] - FAW_WIDTH'(1) : '0;
  end

  always_comb begin
    cmd_valid_d = col_any || row_any;
    cmd_d       = cmd_valid_d ? cmd_t'(bus.req_cmd_i[3*sel +: 3]) : CMD_NOP;
    ba_d        = cmd_valid_d ? sel : ba_q;
    addr_d      = cmd_valid_d ? bus.req_addr_i[ADDR_WIDTH*sel +: ADDR_WIDTH] : addr_q;
    id_d        = cmd_valid_d ? bus.req_id_i[ID_WIDTH*sel +: ID_WIDTH] : id_q;
    col_ptr_d   = col_any ? col_idx + BA_WIDTH'(1) : col_ptr_q;
    row_ptr_d   = (!col_any && row_any) ? row_idx + BA_WIDTH'(1) : row_ptr_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_valid_q <= 1'b0;
      cmd_q       <= CMD_NOP;
      ba_q        <= '0;
      addr_q      <= '0;
      id_q        <= '0;
      col_ptr_q   <= '0;
      row_ptr_q   <= '0;
      faw_cnt_q   <= '{default: '0};
    end else begin
      cmd_valid_q <= cmd_valid_d;
      cmd_q       <= cmd_d;
      ba_q        <= ba_d;
      addr_q      <= addr_d;
      id_q        <= id_d;
      col_ptr_q   <= col_ptr_d;
      row_ptr_q   <= row_ptr_d;
      faw_cnt_q   <= faw_cnt_d;
    end
  end

  assign bus.cmd_valid_o = cmd_valid_q;
  assign bus.cmd_o       = cmd_q;
  assign bus.cmd_ba_o    = ba_q;
  assign bus.cmd_addr_o  = addr_q;
  assign bus.cmd_id_o    = id_q;
endmodule

// File: tb/tb_sal_cmd_arbiter.sv
// tb_sal_cmd_arbiter: scenario tasks plus randomized traffic against a rule-level arbiter model
module tb_sal_cmd_arbiter;
  import sal_cmd_pkg::*;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] t_faw = '0;
  logic [3:0] req_v = '0;
  logic [2:0] req_c [4];
  logic [15:0] req_a [4];
  logic [3:0] req_id [4];
  int checks = 0;
  int errors = 0;
  int col_ptr, row_ptr, cyc, exp_b;
  bit exp_col;
  int act_t [$];
  logic [3:0] exp_gnt;
  logic exp_valid;
  logic [2:0] exp_cmd;
  logic [1:0] exp_ba;
  logic [15:0] exp_addr;
  logic [3:0] exp_id;

  sal_cmd_arbiter_if #(.NUM_BANKS(4), .BA_WIDTH(2), .ADDR_WIDTH(16), .ID_WIDTH(4)) bus ();
  sal_cmd_arbiter #(.NUM_BANKS(4), .BA_WIDTH(2), .ADDR_WIDTH(16), .ID_WIDTH(4), .FAW_WIDTH(6)) dut (
    .clk(clk), .rst(rst), .t_faw_m1_i(t_faw), .bus(bus)
  );

  always #5 clk = ~clk;

  always_comb begin
    for (int b = 0; b < 4; b++) begin
      bus.req_valid_i[b]        = req_v[b];
      bus.req_cmd_i[3*b +: 3]   = req_c[b];
      bus.req_addr_i[16*b +: 16] = req_a[b];
      bus.req_id_i[4*b +: 4]    = req_id[b];
    end
  end

  wire [25:0] act_bus = {bus.cmd_valid_o, bus.cmd_o, bus.cmd_ba_o, bus.cmd_addr_o, bus.cmd_id_o};
  wire [25:0] exp_bus = {exp_valid, exp_cmd, exp_ba, exp_addr, exp_id};

  task automatic model_clear();
    col_ptr = 0;
    row_ptr = 0;
    act_t.delete();
    {exp_valid, exp_cmd, exp_ba, exp_addr, exp_id} = '0;
  endtask

  // Window rule: an ACT granted at cycle g occupies the window through cycle g+tFAW-1.
  task automatic model_eval();
    int n = 0;
    exp_b = -1;
    exp_col = 0;
    foreach (act_t[i]) if (cyc - act_t[i] <= int'(t_faw)) n++;
    for (int k = 0; k < 4; k++) begin
      int b = (col_ptr + k) % 4;
      if (exp_b < 0 && req_v[b] && (req_c[b] == 3'd2 || req_c[b] == 3'd3)) begin exp_b = b; exp_col = 1; end
    end
    for (int k = 0; k < 4; k++) begin
      int b = (row_ptr + k) % 4;
      if (exp_b < 0 && req_v[b] && ((req_c[b] == 3'd1 && n < 4) || req_c[b] == 3'd4 || req_c[b] == 3'd5)) exp_b = b;
    end
    exp_gnt = (exp_b < 0 || rst) ? 4'b0 : 4'(1 << exp_b);
  endtask

  task automatic model_commit();
    if (rst) begin model_clear(); return; end
    if (exp_b >= 0) begin
      exp_valid = 1'b1;
      exp_cmd   = req_c[exp_b];
      exp_ba    = 2'(exp_b);
      exp_addr  = req_a[exp_b];
      exp_id    = req_id[exp_b];
      if (exp_col) col_ptr = (exp_b + 1) % 4; else row_ptr = (exp_b + 1) % 4;
      if (req_c[exp_b] == 3'd1) act_t.push_back(cyc);
    end else begin
      exp_valid = 1'b0;
      exp_cmd   = 3'd0;
    end
    cyc++;
  endtask

  task automatic settle();
    @(negedge clk);
    model_eval();
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic rnd_data();
    for (int b = 0; b < 4; b++) begin
      req_a[b]  = 16'($urandom);
      req_id[b] = 4'($urandom);
    end
  endtask

  task automatic set_all(input logic [2:0] cmd);
    for (int b = 0; b < 4; b++) req_c[b] = cmd;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_clear();
    for (int k = 0; k < 4; k++) begin
      req_v = 4'($urandom);
      for (int b = 0; b < 4; b++) req_c[b] = 3'($urandom_range(1, 5));
      rnd_data();
      @(negedge clk);
      checks++;
      if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL reset_gnt got %b exp 0000", bus.gnt_o); end
      checks++;
      if (act_bus !== 26'b0) begin errors++; $display("FAIL reset_bus got %h exp 0", act_bus); end
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
    req_v = 4'b0100;
    req_c[2] = 3'd2;
    rnd_data();
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0100) begin errors++; $display("FAIL reset_first_gnt got %b exp 0100", bus.gnt_o); end
    tick();
    req_v = '0;
    settle();
    checks++;
    if (bus.cmd_valid_o !== 1'b1 || bus.cmd_o !== CMD_RD || bus.cmd_ba_o !== 2'd2) begin
      errors++; $display("FAIL reset_first_cmd got v=%b cmd=%0d ba=%0d exp v=1 cmd=2 ba=2", bus.cmd_valid_o, bus.cmd_o, bus.cmd_ba_o);
    end
    checks++;
    if (act_bus !== exp_bus) begin errors++; $display("FAIL reset_first_bus got %h exp %h", act_bus, exp_bus); end
    tick();
  endtask

  task automatic test_round_robin();
    t_faw = '0;
    apply_reset();
    req_v = 4'hf;
    set_all(3'd2);
    for (int k = 0; k < 12; k++) begin
      rnd_data();
      settle();
      checks++;
      if (bus.gnt_o !== 4'(1 << (k % 4))) begin errors++; $display("FAIL rr_gnt k=%0d got %b exp %b", k, bus.gnt_o, 4'(1 << (k % 4))); end
      checks++;
      if (act_bus !== exp_bus) begin errors++; $display("FAIL rr_bus k=%0d got %h exp %h", k, act_bus, exp_bus); end
      tick();
    end
    req_v = '0;
  endtask

  task automatic test_priority();
    apply_reset();
    rnd_data();
    req_v = 4'b1001;
    req_c[0] = 3'd1;
    req_c[3] = 3'd3;
    settle();
    checks++;
    if (bus.gnt_o !== 4'b1000) begin errors++; $display("FAIL prio_col_first got %b exp 1000", bus.gnt_o); end
    tick();
    req_v[3] = 1'b0;
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL prio_row_next got %b exp 0001", bus.gnt_o); end
    checks++;
    if (act_bus !== exp_bus) begin errors++; $display("FAIL prio_bus_wr got %h exp %h", act_bus, exp_bus); end
    tick();
    req_v = 4'b0011;
    req_c[0] = 3'd4;
    req_c[1] = 3'd4;
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0010) begin errors++; $display("FAIL prio_row_ptr got %b exp 0010", bus.gnt_o); end
    tick();
    req_v = '0;
  endtask

  task automatic test_tfaw();
    t_faw = 6'd19;
    apply_reset();
    req_v = 4'hf;
    for (int k = 0; k < 26; k++) begin
      bit want;
      set_all(3'd1);
      if (k == 8) req_c[1] = 3'd4;
      rnd_data();
      settle();
      want = (k < 4) || (k == 8) || (k >= 20 && k < 24);
      checks++;
      if ((|bus.gnt_o) !== want) begin errors++; $display("FAIL faw_window k=%0d got %b exp_any %0d", k, bus.gnt_o, want); end
      checks++;
      if (bus.gnt_o !== exp_gnt) begin errors++; $display("FAIL faw_gnt k=%0d got %b exp %b", k, bus.gnt_o, exp_gnt); end
      checks++;
      if (act_bus !== exp_bus) begin errors++; $display("FAIL faw_bus k=%0d got %h exp %h", k, act_bus, exp_bus); end
      tick();
    end
    req_v = '0;
  endtask

  task automatic test_illegal();
    t_faw = '0;
    apply_reset();
    for (int k = 0; k < 8; k++) begin
      req_v = 4'($urandom) | 4'b0001;
      for (int b = 0; b < 4; b++) begin
        int r = $urandom_range(0, 2);
        req_c[b] = (r == 0) ? 3'd0 : 3'(5 + r);
      end
      rnd_data();
      settle();
      checks++;
      if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL illegal_gnt k=%0d got %b exp 0000", k, bus.gnt_o); end
      checks++;
      if (bus.cmd_valid_o !== 1'b0 || act_bus !== exp_bus) begin errors++; $display("FAIL illegal_bus k=%0d got %h exp %h", k, act_bus, exp_bus); end
      tick();
    end
    req_v = 4'hf;
    set_all(3'd2);
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL illegal_col_ptr got %b exp 0001", bus.gnt_o); end
    tick();
    set_all(3'd4);
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0001) begin errors++; $display("FAIL illegal_row_ptr got %b exp 0001", bus.gnt_o); end
    tick();
    req_v = '0;
  endtask

  task automatic test_reset_mid();
    t_faw = 6'd19;
    apply_reset();
    req_v = 4'hf;
    set_all(3'd1);
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      settle();
      checks++;
      if (bus.gnt_o !== exp_gnt || exp_gnt == 4'b0) begin errors++; $display("FAIL mid_fill k=%0d got %b exp %b", k, bus.gnt_o, exp_gnt); end
      tick();
    end
    settle();
    checks++;
    if (bus.gnt_o !== 4'b0) begin errors++; $display("FAIL mid_blocked got %b exp 0000", bus.gnt_o); end
    #2 rst = 1'b1;
    model_clear();
    #1;
    checks++;
    if (bus.gnt_o !== 4'b0 || act_bus !== 26'b0) begin errors++; $display("FAIL mid_async got gnt=%b bus=%h exp 0", bus.gnt_o, act_bus); end
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rnd_data();
      settle();
      checks++;
      if (bus.gnt_o !== exp_gnt || bus.gnt_o == 4'b0) begin errors++; $display("FAIL mid_after k=%0d got %b exp %b", k, bus.gnt_o, exp_gnt); end
      checks++;
      if (act_bus !== exp_bus) begin errors++; $display("FAIL mid_bus k=%0d got %h exp %h", k, act_bus, exp_bus); end
      tick();
    end
    req_v = '0;
  endtask

  task automatic test_random();
    for (int rep = 0; rep < 4; rep++) begin
      t_faw = (rep == 0) ? 6'd0 : 6'($urandom_range(1, 9));
      apply_reset();
      for (int k = 0; k < 150; k++) begin
        req_v = 4'($urandom);
        for (int b = 0; b < 4; b++) req_c[b] = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'($urandom_range(1, 2)) + 3'(($urandom_range(0, 1)) * 2);
        rnd_data();
        settle();
        checks++;
        if (bus.gnt_o !== exp_gnt) begin errors++; $display("FAIL rnd_gnt rep=%0d k=%0d got %b exp %b", rep, k, bus.gnt_o, exp_gnt); end
        checks++;
        if (act_bus !== exp_bus) begin errors++; $display("FAIL rnd_bus rep=%0d k=%0d got %h exp %h", rep, k, act_bus, exp_bus); end
        tick();
      end
    end
    req_v = '0;
  endtask

  initial begin
    cyc = 0;
    set_all(3'd0);
    for (int b = 0; b < 4; b++) begin req_a[b] = '0; req_id[b] = '0; end
    model_clear();
    test_reset();
    test_round_robin();
    test_priority();
    test_tfaw();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
